bin2bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 19 +
 rtl/bin2bcd_seq_if.sv | 16 +
 rtl/bcd_add3.sv | 12 +
 rtl/bin2bcd_seq.sv | 103 ++++++++++
 tb/tb_bin2bcd_seq.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// States, digit width, add-3 threshold and count-register sizing.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_W       = 4;
    localparam int ADD3_THRESH = 5;

    // Count must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a binary source and the BCD converter.
// The master drives start/bin; the converter (slave) drives busy/done/bcd/overflow.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (output start, bin, input busy, done, bcd, overflow);
    modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a digit of 5 or more gets 3 added before the shift.
// Purely combinational, no flow control.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] i_dig,
    output logic [BCD_W-1:0] o_dig
);

    assign o_dig = (i_dig >= BCD_W'(ADD3_THRESH)) ? i_dig + BCD_W'(3) : i_dig;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one input bit per clock; done WIDTH+1 cycles after accept.
// start is ignored while converting (no queueing); results hold until the next done pulse.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic          Clock,
    input  logic          Resetn,
    bin2bcd_seq_if.slave  bus
);

    localparam int CW = cnt_w(WIDTH);
    localparam int SW = BCD_W * DIGITS;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic [SW-1:0]    r_scr,   w_scr_nxt;
    logic [SW-1:0]    w_adj;
    logic             r_ovf_scr, w_ovf_scr_nxt;
    logic [CW-1:0]    r_cnt,   w_cnt_nxt;
    logic             w_accept;

    logic             r_busy;
    logic             r_done;
    logic [SW-1:0]    r_bcd;
    logic             r_ovf;

    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
        bcd_add3 u_add3 (
            .i_dig (r_scr[k*BCD_W +: BCD_W]),
            .o_dig (w_adj[k*BCD_W +: BCD_W])
        );
    end

    assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_scr_nxt     = r_scr;
        w_ovf_scr_nxt = r_ovf_scr;
        w_cnt_nxt     = r_cnt;

        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_shift_nxt   = bus.bin;
                    w_scr_nxt     = '0;
                    w_ovf_scr_nxt = 1'b0;
                    w_cnt_nxt     = CW'(WIDTH);
                    w_state_nxt   = SHIFT;
                end else begin
                    w_state_nxt   = IDLE;
                end
            end
            SHIFT: begin
                // Bit leaving the top digit is a carry into a digit we don't have.
                w_shift_nxt   = r_shift << 1;
                w_scr_nxt     = {w_adj[SW-2:0], r_shift[WIDTH-1]};
                w_ovf_scr_nxt = r_ovf_scr | w_adj[SW-1];
                w_cnt_nxt     = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_scr     <= '0;
            r_ovf_scr <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_scr     <= w_scr_nxt;
            r_ovf_scr <= w_ovf_scr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= (r_state == SHIFT);
            r_done    <= (r_state == DONE);
            if (r_state == DONE) begin
                r_bcd <= r_scr;
                r_ovf <= r_ovf_scr;
            end
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.bcd      = r_bcd;
    assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: 8-bit and 10-bit instances against a divide/modulo reference.
// Covers reset, latency/busy timing, start-while-busy, back-to-back, async abort and overflow.
module tb_bin2bcd_seq;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;

    always #5 Clock = ~Clock;

    bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) if8  ();
    bin2bcd_seq_if #(.WIDTH(10), .DIGITS(3)) if10 ();

    bin2bcd_seq #(.WIDTH(8),  .DIGITS(3)) dut8  (.Clock(Clock), .Resetn(Resetn), .bus(if8));
    bin2bcd_seq #(.WIDTH(10), .DIGITS(3)) dut10 (.Clock(Clock), .Resetn(Resetn), .bus(if10));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Reference: decimal digits of (v mod 1000) packed as BCD.
    function automatic logic [11:0] ref_bcd(input int v);
        int r;
        r = v % 1000;
        return {4'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
    endfunction

    function automatic logic ref_ovf(input int v);
        return v >= 1000;
    endfunction

    task automatic drive(input bit wide, input bit st, input int v);
        if (wide) begin
            if10.start = st;
            if10.bin   = 10'(v);
        end else begin
            if8.start  = st;
            if8.bin    = 8'(v);
        end
    endtask

    function automatic logic o_busy(input bit wide);
        return wide ? if10.busy : if8.busy;
    endfunction

    function automatic logic o_done(input bit wide);
        return wide ? if10.done : if8.done;
    endfunction

    function automatic logic [11:0] o_bcd(input bit wide);
        return wide ? if10.bcd : if8.bcd;
    endfunction

    function automatic logic o_ovf(input bit wide);
        return wide ? if10.overflow : if8.overflow;
    endfunction

    // One conversion from IDLE; called just after an active edge.
    task automatic conv(input bit wide, input int v);
        int w;
        int done_cyc;
        int busy_n;
        w        = wide ? 10 : 8;
        done_cyc = -1;
        busy_n   = 0;
        drive(wide, 1'b1, v);
        @(posedge Clock); #1;
        drive(wide, 1'b0, int'($urandom));
        for (int c = 1; c <= w + 6; c++) begin
            @(posedge Clock); #1;
            if (o_busy(wide) && c <= w) busy_n++;
            if (o_done(wide)) begin
                done_cyc = c;
                break;
            end
        end
        check($sformatf("latency w=%0d v=%0d", w, v), done_cyc, w + 1);
        check($sformatf("busy_cycles w=%0d v=%0d", w, v), busy_n, w);
        check($sformatf("bcd w=%0d v=%0d", w, v), o_bcd(wide), ref_bcd(v));
        check($sformatf("ovf w=%0d v=%0d", w, v), o_ovf(wide), ref_ovf(v));
        @(posedge Clock); #1;
        check($sformatf("done_pulse w=%0d v=%0d", w, v), o_done(wide), 1'b0);
    endtask

    initial begin
        int dc[$];
        logic [11:0] db[$];
        int seen;

        drive(1'b0, 1'b0, 0);
        drive(1'b1, 1'b0, 0);
        #23;
        check("rst busy8", if8.busy, 1'b0);
        check("rst done8", if8.done, 1'b0);
        check("rst bcd8",  if8.bcd,  12'h000);
        check("rst ovf8",  if8.overflow, 1'b0);
        check("rst busy10", if10.busy, 1'b0);
        Resetn = 1'b1;
        @(posedge Clock); #1;

        conv(1'b0, 0);
        conv(1'b0, 255);
        conv(1'b0, 99);
        conv(1'b0, 129);
        conv(1'b1, 1000);
        conv(1'b1, 1023);
        conv(1'b1, 999);

        // start while busy is dropped; start held across DONE chains a new conversion
        drive(1'b0, 1'b1, 200);
        @(posedge Clock); #1;
        for (int c = 1; c <= 25; c++) begin
            if (c == 3 || c == 8 || c == 9) drive(1'b0, 1'b1, 17);
            else                             drive(1'b0, 1'b0, int'($urandom));
            @(posedge Clock); #1;
            if (if8.done) begin
                dc.push_back(c);
                db.push_back(if8.bcd);
            end
        end
        check("b2b done_count", dc.size(), 2);
        while (dc.size() < 2) begin
            dc.push_back(-1);
            db.push_back(12'hfff);
        end
        check("b2b first_cyc",  dc[0], 9);
        check("b2b first_bcd",  db[0], 12'h200);
        check("b2b second_cyc", dc[1], 18);
        check("b2b second_bcd", db[1], 12'h017);

        // asynchronous reset in the middle of a conversion
        drive(1'b0, 1'b1, 255);
        @(posedge Clock); #1;
        drive(1'b0, 1'b0, 0);
        repeat (4) @(posedge Clock);
        #2;
        Resetn = 1'b0;
        #1;
        check("abort busy", if8.busy, 1'b0);
        check("abort done", if8.done, 1'b0);
        check("abort bcd",  if8.bcd,  12'h000);
        check("abort ovf",  if8.overflow, 1'b0);
        check("abort bcd10", if10.bcd, 12'h000);
        #10;
        Resetn = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge Clock); #1;
            if (if8.done || if8.busy) seen++;
        end
        check("abort no_activity", seen, 0);
        conv(1'b0, 255);

        for (int v = 0; v < 256; v++) conv(1'b0, v);
        for (int i = 0; i < 40; i++)  conv(1'b1, int'($urandom_range(0, 1023)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
